// File: rtl/cpu_defs.sv
// Shared CPU encodings: bus arbiter FSM states, bus owner ids and access sizes.
package cpu_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// Tie policy: ARB_ROUND_ROBIN_EN alternates on ties, otherwise data always wins.
module arb_pick
  import cpu_defs::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  output logic grant,
  output logic pick
);

  assign grant = inst_req | data_req;

  always_comb begin
    pick = OWN_INST;
    if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = ~last_owner;
`else
      pick = OWN_DATA;
`endif
    end else if (data_req) begin
      pick = OWN_DATA;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and load/store; one transaction in flight.
// Tie-break policy selectable with ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_bus_arbiter
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arb_state_t  state, state_nxt;
  logic        owner, last_owner;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        grant, pick, arb_pt;

  arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (last_owner),
    .grant      (grant),
    .pick       (pick)
  );

  // Arbitrate when idle, or on the completing cycle of WAIT so the next grant has no bubble.
  assign arb_pt = (state == ARB_IDLE) || (state == ARB_WAIT && bus_data_ok);

  always_comb begin
    state_nxt    = state;
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    case (state)
      ARB_IDLE: if (grant) state_nxt = ARB_ADDR;
      ARB_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          state_nxt    = ARB_WAIT;
          inst_addr_ok = (owner == OWN_INST);
          data_addr_ok = (owner == OWN_DATA);
        end
      end
      ARB_WAIT: begin
        if (bus_data_ok) begin
          state_nxt = grant ? ARB_ADDR : ARB_IDLE;
          if (owner == OWN_INST) begin
            inst_data_ok = 1'b1;
            inst_rdata   = bus_rdata;
          end else begin
            data_data_ok = 1'b1;
            data_rdata   = bus_rdata;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= OWN_INST;
      last_owner <= OWN_DATA;
      wr_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (arb_pt && grant) begin
      owner      <= pick;
      last_owner <= pick;
      if (pick == OWN_DATA) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end else begin
        wr_q    <= 1'b0;
        size_q  <= SIZE_WORD;
        addr_q  <= inst_addr;
        wdata_q <= '0;
      end
    end
  end

  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter plus multi-cycle corner sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  logic [135:0] outv;
  assign outv = {bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
                 inst_addr_ok, inst_data_ok, inst_rdata,
                 data_addr_ok, data_data_ok, data_rdata};

  typedef struct {
    string        nm;
    logic         ireq;
    logic [31:0]  iaddr;
    logic         dreq, dwr;
    logic [1:0]   dsz;
    logic [31:0]  daddr, dwd;
    logic         baok, bdok;
    logic [31:0]  brd;
    logic [135:0] exp;
  } vec_t;

  function automatic logic [135:0] ex(logic breq, logic bwr, logic [1:0] bsz,
      logic [31:0] baddr, logic [31:0] bwd, logic iaok, logic idok, logic [31:0] ird,
      logic daok, logic ddok, logic [31:0] drd);
    return {breq, bwr, bsz, baddr, bwd, iaok, idok, ird, daok, ddok, drd};
  endfunction

  function automatic vec_t mkv(string nm, logic ireq, logic [31:0] iaddr, logic dreq,
      logic dwr, logic [1:0] dsz, logic [31:0] daddr, logic [31:0] dwd, logic baok,
      logic bdok, logic [31:0] brd, logic [135:0] exp);
    vec_t v;
    v.nm = nm; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr; v.dsz = dsz;
    v.daddr = daddr; v.dwd = dwd; v.baok = baok; v.bdok = bdok; v.brd = brd; v.exp = exp;
    return v;
  endfunction

  task automatic drive(logic ireq, logic [31:0] iaddr, logic dreq, logic dwr,
      logic [1:0] dsz, logic [31:0] daddr, logic [31:0] dwd, logic baok, logic bdok,
      logic [31:0] brd);
    inst_req = ireq; inst_addr = iaddr; data_req = dreq; data_wr = dwr;
    data_size = dsz; data_addr = daddr; data_wdata = dwd;
    bus_addr_ok = baok; bus_data_ok = bdok; bus_rdata = brd;
  endtask

  task automatic chk(string nm, logic [135:0] act, logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Inputs are applied just after the falling edge; outputs are sampled 2 units later.
  task automatic run(string nm, logic [135:0] exp);
    #2;
    chk(nm, outv, exp);
    @(negedge clk);
  endtask

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [31:0] Z = 32'h0;

  vec_t vecs[15];

  initial begin
    vecs[0]  = mkv("fetch_idle",  I, 32'hBFC00000, O, O, 2'd0, Z, Z, O, O, Z,
                   ex(O, O, 2'd0, Z, Z, O, O, Z, O, O, Z));
    vecs[1]  = mkv("fetch_aok",   I, 32'hBFC00000, O, O, 2'd0, Z, Z, I, O, Z,
                   ex(I, O, 2'd2, 32'hBFC00000, Z, I, O, Z, O, O, Z));
    vecs[2]  = mkv("fetch_dok",   O, Z, O, O, 2'd0, Z, Z, O, I, 32'h3C1D0001,
                   ex(O, O, 2'd2, 32'hBFC00000, Z, O, I, 32'h3C1D0001, O, O, Z));
    vecs[3]  = mkv("idle_bdok",   O, Z, O, O, 2'd0, Z, Z, O, I, 32'h12345678,
                   ex(O, O, 2'd2, 32'hBFC00000, Z, O, O, Z, O, O, Z));
    vecs[4]  = mkv("tie_idle",    I, 32'hBFC00004, I, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, O, Z,
                   ex(O, O, 2'd2, 32'hBFC00000, Z, O, O, Z, O, O, Z));
    vecs[5]  = mkv("addr_bdok",   I, 32'hBFC00004, I, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, I, 32'h55555555,
                   ex(I, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, O, Z, O, O, Z));
    vecs[6]  = mkv("store_aok",   I, 32'hBFC00004, I, I, 2'd2, 32'h80001000, 32'hDEADBEEF, I, O, Z,
                   ex(I, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, O, Z, I, O, Z));
    vecs[7]  = mkv("store_wait",  I, 32'hBFC00004, O, O, 2'd0, Z, Z, O, O, Z,
                   ex(O, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, O, Z, O, O, Z));
    vecs[8]  = mkv("store_dok",   I, 32'hBFC00004, O, O, 2'd0, Z, Z, O, I, 32'hCAFEF00D,
                   ex(O, I, 2'd2, 32'h80001000, 32'hDEADBEEF, O, O, Z, O, I, 32'hCAFEF00D));
    vecs[9]  = mkv("b2b_fetch",   I, 32'hBFC00004, O, O, 2'd0, Z, Z, O, O, Z,
                   ex(I, O, 2'd2, 32'hBFC00004, Z, O, O, Z, O, O, Z));
    vecs[10] = mkv("fetch2_aok",  I, 32'hBFC00004, O, O, 2'd0, Z, Z, I, O, Z,
                   ex(I, O, 2'd2, 32'hBFC00004, Z, I, O, Z, O, O, Z));
    vecs[11] = mkv("fetch2_dok",  O, Z, O, O, 2'd0, Z, Z, O, I, 32'h11112222,
                   ex(O, O, 2'd2, 32'hBFC00004, Z, O, I, 32'h11112222, O, O, Z));
    vecs[12] = mkv("byte_idle",   O, Z, I, O, 2'd0, 32'h80002003, 32'h000000AA, O, O, Z,
                   ex(O, O, 2'd2, 32'hBFC00004, Z, O, O, Z, O, O, Z));
    vecs[13] = mkv("byte_aok",    O, Z, I, O, 2'd0, 32'h80002003, 32'h000000AA, I, O, Z,
                   ex(I, O, 2'd0, 32'h80002003, 32'h000000AA, O, O, Z, I, O, Z));
    vecs[14] = mkv("byte_dok",    O, Z, O, O, 2'd0, Z, Z, O, I, 32'h000000AB,
                   ex(O, O, 2'd0, 32'h80002003, 32'h000000AA, O, O, Z, O, I, 32'h000000AB));

    resetn = 1'b0;
    drive(I, 32'hBFC00000, I, I, 2'd2, 32'h1, 32'h2, I, I, 32'hFFFFFFFF);
    @(negedge clk);
    run("reset_outputs", '0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwr, vecs[i].dsz,
            vecs[i].daddr, vecs[i].dwd, vecs[i].baok, vecs[i].bdok, vecs[i].brd);
      run(vecs[i].nm, vecs[i].exp);
    end

    // Bus withholds addr_ok for 5 cycles: request must hold steady, no early addr_ok.
    drive(O, Z, I, O, 2'd1, 32'h80003000, Z, O, O, Z);
    run("stall_idle", ex(O, O, 2'd0, 32'h80002003, 32'h000000AA, O, O, Z, O, O, Z));
    for (int k = 0; k < 5; k++)
      run("stall_hold", ex(I, O, 2'd1, 32'h80003000, Z, O, O, Z, O, O, Z));
    bus_addr_ok = 1'b1;
    run("stall_accept", ex(I, O, 2'd1, 32'h80003000, Z, O, O, Z, I, O, Z));
    drive(O, Z, O, O, 2'd0, Z, Z, O, I, 32'h0000BEEF);
    run("stall_dok", ex(O, O, 2'd1, 32'h80003000, Z, O, O, Z, O, I, 32'h0000BEEF));

    // Repeated ties from a fresh reset.
    resetn = 1'b0;
    drive(O, Z, O, O, 2'd0, Z, Z, O, O, Z);
    @(negedge clk);
    resetn = 1'b1;
    drive(I, 32'hA0000000, I, O, 2'd2, 32'hA0000100, Z, O, O, Z);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      logic inst_wins;
`ifdef ARB_ROUND_ROBIN_EN
      inst_wins = (k % 2 == 0);
`else
      inst_wins = 1'b0;
`endif
      bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
      if (inst_wins) run("tie_grant", ex(I, O, 2'd2, 32'hA0000000, Z, I, O, Z, O, O, Z));
      else           run("tie_grant", ex(I, O, 2'd2, 32'hA0000100, Z, O, O, Z, I, O, Z));
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      @(negedge clk);
    end
    drive(O, Z, O, O, 2'd0, Z, Z, I, O, Z);
    @(negedge clk);
    drive(O, Z, O, O, 2'd0, Z, Z, O, I, Z);
    @(negedge clk);

    // Reset during WAIT, then a late data_ok after release.
    drive(I, 32'hBFC00100, O, O, 2'd0, Z, Z, O, O, Z);
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    drive(O, Z, O, O, 2'd0, Z, Z, O, I, 32'h99999999);
    resetn = 1'b0;
    run("reset_in_wait", '0);
    resetn = 1'b1;
    run("late_dok_ignored", '0);
    drive(I, 32'hBFC00200, O, O, 2'd0, Z, Z, O, O, Z);
    @(negedge clk);
    bus_addr_ok = 1'b1;
    run("post_reset_aok", ex(I, O, 2'd2, 32'hBFC00200, Z, I, O, Z, O, O, Z));
    drive(O, Z, O, O, 2'd0, Z, Z, O, I, 32'h77777777);
    run("post_reset_dok", ex(O, O, 2'd2, 32'hBFC00200, Z, O, I, 32'h77777777, O, O, Z));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single SRAM-like memory bus between the fetch port (`inst_*`) and the load/store port (`data_*`) of the 5-stage pipeline. At most one transaction is outstanding at a time. Each requester sees its own SRAM-like handshake: it holds `req` until `addr_ok`, then waits for `data_ok`. The pipeline converts a missing `addr_ok` or `data_ok` into stallF/stallD/flushE alongside the hazard logic.

## Interface
- No parameters; all widths are fixed at 32-bit address and 32-bit data.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request; held until `inst_addr_ok`.
- `inst_addr` in 32: fetch address.
- `inst_addr_ok` out 1: fetch request accepted by the bus.
- `inst_data_ok` out 1: fetch data valid.
- `inst_rdata` out 32: fetch data.
- `data_req` in 1: load/store request; held until `data_addr_ok`.
- `data_wr` in 1: 1 = store.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` in 32 / `data_wdata` in 32: access address and store data.
- `data_addr_ok` out 1 / `data_data_ok` out 1 / `data_rdata` out 32: load/store handshake and read data.
- `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_addr` out 32, `bus_wdata` out 32: request to memory.
- `bus_addr_ok` in 1, `bus_data_ok` in 1, `bus_rdata` in 32: memory responses.

## Operation
- FSM states: IDLE, ADDR, WAIT. Registers: `owner` (0 = inst, 1 = data), `last_owner`, and latched request fields (`wr`, `size`, `addr`, `wdata`).
- Arbitration runs in IDLE, and in WAIT on the cycle `bus_data_ok` is high.
  - Only one requester present: grant it.
  - Both present: default is data wins.
  - On grant: latch the winner's fields into the request registers. An inst grant latches `wr` = 0 and `size` = 2. Set `owner` and `last_owner`, then go to ADDR.
  - No request: go to (or stay in) IDLE.
- ADDR:
  - `bus_req` = 1; bus fields come from the latched registers.
  - On `bus_addr_ok`: pulse the owner's `*_addr_ok` combinationally in the same cycle, then go to WAIT.
- WAIT:
  - `bus_req` = 0.
  - On `bus_data_ok`: pulse the owner's `*_data_ok` combinationally and drive the owner's `*_rdata` = `bus_rdata`, then re-arbitrate as above.
- The non-owner's `addr_ok`, `data_ok` and `rdata` are 0 at all times.
- A requester that is not granted keeps `req` high. It is considered again at the next arbitration point.
- Protocol violations are ignored:
  - `bus_data_ok` in IDLE or ADDR.
  - `bus_addr_ok` outside ADDR.
- Stores complete on `data_data_ok` exactly like loads; `rdata` is don't-care for stores but is still forwarded.

## Timing
- Reset: state IDLE, `owner` 0, `last_owner` 1, all latched fields 0.
  - Every output is 0: `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`, all `*_addr_ok`, `*_data_ok`, `*_rdata`.
- Request-to-bus latency from IDLE: `req` seen in cycle N gives `bus_req` high in N+1. `*_addr_ok` is no earlier than N+1.
- Back-to-back: `bus_data_ok` in cycle M with a pending request gives `bus_req` in M+1, with no idle bubble.
- Minimum transaction: 2 cycles bus-side (ADDR with immediate `addr_ok`, then WAIT with `data_ok` on the next cycle).
- Latched fields are stable from ADDR entry until the next grant. Requester inputs may change after `addr_ok`.
- Reset asserted mid-transaction: immediately return to IDLE; the outstanding transaction is abandoned. A late `bus_data_ok` after release is ignored because the FSM is in IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: on a tie, grant `!last_owner`, so requesters alternate. The first tie after reset goes to inst.
  - Undefined: data always wins a tie. `last_owner` is still maintained but unused.

## Structure
- The shared `cpu_defs` package holds:
  - state encodings `ARB_IDLE`, `ARB_ADDR`, `ARB_WAIT`;
  - owner encodings `OWN_INST`, `OWN_DATA`;
  - size constants `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
- One sub-module, `arb_pick`: combinational winner select taking `inst_req`, `data_req` and `last_owner`. The `ARB_ROUND_ROBIN_EN` policy lives only there.

## Test plan
- Lone fetch `0xBFC00000`, bus `addr_ok` at first ADDR cycle, `data_ok` 1 cycle later with `0x3C1D0001` -> `bus_wr` = 0, `bus_size` = 2, `inst_data_ok` pulse with `inst_rdata` = `0x3C1D0001`, `data_*` stay 0.
- Fetch and store (`addr 0x80001000`, `wdata 0xDEADBEEF`, size 2) raised together, macro undefined -> store granted first, fetch on `bus_req` the cycle after store `data_ok`.
- Same tie repeated 4 times with `ARB_ROUND_ROBIN_EN` -> grant order inst, data, inst, data.
- Bus holds `addr_ok` low 5 cycles -> `bus_req` and `bus_addr` stable all 5 cycles, owner `addr_ok` only on the accept cycle.
- `bus_data_ok` injected in IDLE and ADDR -> no `*_data_ok` pulse, state unchanged.
- `resetn` low during WAIT, then `bus_data_ok` after release -> all outputs 0, no `data_ok` forwarded, the next request is served normally.
